// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier.
// The default widths match the divider: the multiplicand is the
// quotient/dividend width and the multiplier is the divisor width.
package mult_pkg;

  localparam int A_W_DEF = 40;
  localparam int B_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The step counter must reach B_W-1.
  function automatic int cnt_width(input int b_w);
    return (b_w > 1) ? $clog2(b_w) : 1;
  endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// Synchronous operand FIFO for the multiplier.
// Ports:
//   clk, reset (async, active-low)
//   push / wr_data : write one entry; ignored while full
//   pop  / rd_data : rd_data is the head entry; pop is ignored while empty
//   full, empty    : decoded from the occupancy count
module mul_operand_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multiplication.sv
// Iterative signed multiplier, the inverse datapath of the divider.
// Operand pairs are queued in a small FIFO; each pair is multiplied by
// B_W radix-2 shift-add steps on magnitudes, with the sign applied at the end.
// Ports:
//   clk, reset (async, active-low)
//   input_valid / input_ready        : operand handshake, ready = FIFO not full
//   multiplicand_data [A_W-1:0]      : signed operand A
//   multiplier_data   [B_W-1:0]      : signed operand B
//   prod_valid                       : one-cycle result pulse (no backpressure)
//   prod_data [A_W+B_W-1:0]          : signed A*B, held until the next result
module multiplication
  import mult_pkg::*;
#(
  parameter int A_W        = A_W_DEF,
  parameter int B_W        = B_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               input_valid,
  output logic               input_ready,
  input  logic [A_W-1:0]     multiplicand_data,
  input  logic [B_W-1:0]     multiplier_data,
  output logic               prod_valid,
  output logic [A_W+B_W-1:0] prod_data
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = cnt_width(B_W);

  state_t           state;
  state_t           state_nx;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [P_W-1:0]   fifo_head;
  logic [A_W-1:0]   head_a;
  logic [B_W-1:0]   head_b;

  logic [A_W-1:0]   a_mag;
  logic [B_W-1:0]   b_shift;
  logic             neg;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   pp;
  logic [P_W-1:0]   acc_sum;
  logic             last_step;

  assign input_ready = !fifo_full;

  mul_operand_fifo #(
    .WIDTH (P_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (input_valid && input_ready),
    .pop     (pop),
    .wr_data ({multiplicand_data, multiplier_data}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_a = fifo_head[P_W-1:B_W];
  assign head_b = fifo_head[B_W-1:0];

  // Unary minus on the most-negative value yields 2^(W-1), which is the
  // exact magnitude when read as unsigned.
  assign last_step = (cnt == CNT_W'(B_W - 1));
  assign pp        = b_shift[0] ? (P_W'(a_mag) << cnt) : '0;
  assign acc_sum   = acc + pp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (last_step) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_mag      <= '0;
      b_shift    <= '0;
      neg        <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      prod_valid <= 1'b0;
      prod_data  <= '0;
    end else begin
      prod_valid <= 1'b0;
      if (pop) begin
        a_mag   <= head_a[A_W-1] ? -head_a : head_a;
        b_shift <= head_b[B_W-1] ? -head_b : head_b;
        neg     <= head_a[A_W-1] ^ head_b[B_W-1];
        cnt     <= '0;
        acc     <= '0;
      end else if (state == BUSY) begin
        acc     <= acc_sum;
        b_shift <= b_shift >> 1;
        cnt     <= cnt + CNT_W'(1);
        // The final partial product is folded in here rather than waiting
        // a cycle for acc, keeping latency at B_W+1 edges.
        if (last_step) begin
          prod_data  <= neg ? -acc_sum : acc_sum;
          prod_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed self-checking bench for the iterative multiplier.
module tb_multiplication;

  localparam int A_W = 40;
  localparam int B_W = 32;
  localparam int P_W = 72;
  localparam int LAT = 33;

  logic           clk;
  logic           reset;
  logic           input_valid;
  logic           input_ready;
  logic [A_W-1:0] multiplicand_data;
  logic [B_W-1:0] multiplier_data;
  logic           prod_valid;
  logic [P_W-1:0] prod_data;

  multiplication #(
    .A_W        (A_W),
    .B_W        (B_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .input_valid       (input_valid),
    .input_ready       (input_ready),
    .multiplicand_data (multiplicand_data),
    .multiplier_data   (multiplier_data),
    .prod_valid        (prod_valid),
    .prod_data         (prod_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [P_W-1:0] data;
    int             edge_n;
  } res_t;
  res_t resq[$];

  always @(negedge clk) begin
    res_t r;
    if (prod_valid === 1'b1) begin
      r.data   = prod_data;
      r.edge_n = cyc;
      resq.push_back(r);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic signed [P_W-1:0] obs,
                     input logic signed [P_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      output int acc_edge, output logic rdy);
    input_valid       = 1'b1;
    multiplicand_data = a;
    multiplier_data   = b;
    rdy               = input_ready;
    acc_edge          = cyc + 1;
    tick();
    input_valid       = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && resq.size() < n; i++) @(negedge clk);
    chk(tag, resq.size(), n);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    res_t r;
    int   e0;
    int   e_acc [6];
    logic rdy;
    logic rdy_v [6];

    input_valid       = 1'b0;
    multiplicand_data = '0;
    multiplier_data   = '0;
    reset             = 1'b0;
    #2;
    chk("ready_in_reset", input_ready, 1);
    chk("valid_in_reset", prod_valid, 0);
    chk("data_in_reset", prod_data, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("ready_after_reset", input_ready, 1);

    // Signed basic
    send(-40'sd1072, -32'sd2296, e0, rdy);
    chk("basic_ready", rdy, 1);
    wait_results(1, 60, "basic_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("basic_data", r.data, 72'sd2461312);
      chk("basic_latency", r.edge_n - e0, LAT);
    end
    repeat (10) tick();
    chk("basic_hold", prod_data, 72'sd2461312);
    chk("basic_no_extra", resq.size(), 0);

    // Back-to-back issue
    send(40'sd100, 32'sd8060928, e_acc[0], rdy_v[0]);
    send(-40'sd2, -32'sd1, e_acc[1], rdy_v[1]);
    send(-40'sd1072, -32'sd2296, e_acc[2], rdy_v[2]);
    chk("b2b_ready", {rdy_v[0], rdy_v[1], rdy_v[2]}, 3'b111);
    wait_results(3, 150, "b2b_count");
    if (resq.size() >= 3) begin
      r = resq.pop_front();
      chk("b2b_data0", r.data, 72'sd806092800);
      chk("b2b_latency0", r.edge_n - e_acc[0], LAT);
      e0 = r.edge_n;
      r = resq.pop_front();
      chk("b2b_data1", r.data, 72'sd2);
      chk("b2b_space1", r.edge_n - e0, LAT);
      e0 = r.edge_n;
      r = resq.pop_front();
      chk("b2b_data2", r.data, 72'sd2461312);
      chk("b2b_space2", r.edge_n - e0, LAT);
    end
    repeat (40) tick();
    chk("b2b_no_extra", resq.size(), 0);

    // FIFO full: six consecutive valid cycles from reset
    do_reset();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++)
      send(40'(i + 1), 32'(i + 10), e_acc[i], rdy_v[i]);
    chk("full_ready_first5",
        {rdy_v[0], rdy_v[1], rdy_v[2], rdy_v[3], rdy_v[4]}, 5'b11111);
    chk("full_ready_sixth", rdy_v[5], 0);
    wait_results(5, 5 * LAT + 50, "full_count");
    if (resq.size() >= 5) begin
      r = resq.pop_front(); chk("full_data0", r.data, 72'sd10);
      r = resq.pop_front(); chk("full_data1", r.data, 72'sd22);
      r = resq.pop_front(); chk("full_data2", r.data, 72'sd36);
      r = resq.pop_front(); chk("full_data3", r.data, 72'sd52);
      r = resq.pop_front(); chk("full_data4", r.data, 72'sd70);
    end
    repeat (50) tick();
    chk("full_no_sixth", resq.size(), 0);

    // Extremes
    send(40'h80_0000_0000, 32'h8000_0000, e0, rdy);
    wait_results(1, 60, "ext_minmin_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("ext_minmin", r.data, 72'h40_0000_0000_0000_0000);
    end
    send(40'h80_0000_0000, 32'h7FFF_FFFF, e0, rdy);
    wait_results(1, 60, "ext_minmax_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("ext_minmax", r.data, 72'hC0_0000_0080_0000_0000);
    end
    send(40'sd0, -32'sd5, e0, rdy);
    wait_results(1, 60, "ext_zero_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("ext_zero", r.data, 72'sd0);
    end
    send(40'h7F_FFFF_FFFF, -32'sd1, e0, rdy);
    wait_results(1, 60, "ext_maxneg1_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("ext_maxneg1", r.data, 72'hFF_FFFF_FF80_0000_0001);
    end

    // Reset mid-operation
    send(40'sd11, 32'sd13, e_acc[0], rdy_v[0]);
    send(40'sd17, 32'sd19, e_acc[1], rdy_v[1]);
    send(40'sd23, 32'sd29, e_acc[2], rdy_v[2]);
    repeat (9) tick();
    reset = 1'b0;
    #2;
    chk("midrst_ready_in_reset", input_ready, 1);
    chk("midrst_data_in_reset", prod_data, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_ready_after", input_ready, 1);
    repeat (80) tick();
    chk("midrst_no_pulse", resq.size(), 0);
    chk("midrst_data_zero", prod_data, 0);
    send(40'sd3, -32'sd7, e0, rdy);
    wait_results(1, 60, "midrst_new_count");
    if (resq.size() >= 1) begin
      r = resq.pop_front();
      chk("midrst_new_data", r.data, -72'sd21);
      chk("midrst_new_latency", r.edge_n - e0, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplication.md
# multiplication

Iterative signed multiplier that is the inverse datapath of the divider. It takes a 40-bit quotient-width operand and a 32-bit divisor-width operand and returns their full-width product, so a quotient times its divisor reconstructs the dividend. It sits beside the divider behind the same valid-style interface, and adds a small input FIFO so upstream can issue back-to-back requests.

## Interface
- `A_W`, default 40: multiplicand width (matches quotient/dividend width).
- `B_W`, default 32: multiplier width (matches divisor width).
- `FIFO_DEPTH`, default 4: input operand FIFO depth; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `input_valid`  in  1  request strobe; the operand pair is accepted on an edge where `input_valid && input_ready`.
- `input_ready`  out  1  high when the FIFO is not full.
- `multiplicand_data`  in  A_W  signed two's-complement operand A.
- `multiplier_data`  in  B_W  signed two's-complement operand B.
- `prod_valid`  out  1  one-cycle pulse marking a new result.
- `prod_data`  out  A_W+B_W  signed product A×B; holds its value until the next result.

## Operation
- **Input FIFO.** Stores {A, B} pairs.
  - Push on `input_valid && input_ready`.
  - `input_ready = !full`, decoded combinationally from the occupancy count.
  - `input_valid` while full is ignored: no write, no error.
  - When the FIFO is full, a pop on the same edge does not enable a push; ready is low for that cycle.
- **FSM states: IDLE, BUSY.**
  - IDLE: if the FIFO is non-empty, pop the head and load `|A|` into an A_W-bit unsigned register and `|B|` into a B_W-bit shift register. Record `neg = A[msb] ^ B[msb]`, clear the accumulator and the counter, then go to BUSY. If the FIFO is empty, stay in IDLE.
  - BUSY: one radix-2 shift-add step per cycle, B_W steps in total.
    - If the B lsb is 1, add `|A|` shifted left by the counter value into the accumulator.
    - Shift B right by one and increment the counter.
    - On the final step (counter = B_W−1), compute the accumulator value including that step's partial product. Register it into `prod_data`, two's-complement negated when `neg` is set. Set `prod_valid` and return to IDLE.
- **Arithmetic.**
  - The accumulator is A_W+B_W bits and unsigned.
  - Magnitudes of the most-negative inputs are exact: |−2^(A_W−1)| fits in A_W unsigned bits.
  - The full result range fits in A_W+B_W signed bits. No truncation and no saturation.
  - A zero operand gives `prod_data = 0`.
- **Output.** There is no output backpressure; the consumer must take the result in its `prod_valid` cycle. `prod_data` is stable between pulses.
- **Reset.** Asynchronous assertion clears the FIFO (count and pointers), the FSM (to IDLE), the counter, the accumulator, `prod_valid` (to 0) and `prod_data` (to 0).
  - `input_ready` reads 1 during and after reset.
  - An in-flight operation is discarded and produces no pulse.

## Timing
- Take E0 as the accepting edge, with the block in IDLE and the FIFO empty.
  - E1: pop and load.
  - E1+1 … E1+B_W: shift-add steps.
  - `prod_valid` rises after edge E1+B_W, i.e. E0+33 for B_W=32, and falls after the next edge.
- Latency is B_W+1 edges from acceptance to `prod_valid`.
- Initiation interval is B_W+1 cycles (IDLE pops again on the edge right after the result edge).
- Sustained issue faster than one pair per B_W+1 cycles fills the FIFO; the overflow is throttled through `input_ready`.
- Results come out strictly in acceptance order.

## Structure
- **Shared package `mult_pkg`:**
  - `A_W`/`B_W` defaults shared with the divider's widths.
  - State enum {IDLE, BUSY}.
  - Counter width `$clog2(B_W)`.
- **Sub-module `mul_operand_fifo`:** synchronous FIFO, A_W+B_W wide, FIFO_DEPTH deep.
  - Signals: push, pop, full, empty, head data.
  - Pointers wrap modulo FIFO_DEPTH; count is 0…FIFO_DEPTH.
  - Async active-low reset.
- The top level holds the FSM, the sign handling and the shift-add datapath.

## Test plan
- **Signed basic.** Single pair A=−1072, B=−2296 → one `prod_valid` pulse 33 edges after acceptance, `prod_data` = 2461312.
- **Back-to-back issue.** Three consecutive cycles of (100, 8060928), (−2, −1), (−1072, −2296), then `input_valid` low → exactly three pulses spaced 33 cycles apart, in order 806092800, 2, 2461312.
- **FIFO full.** Six consecutive valid cycles from reset (FIFO_DEPTH=4) → the first five are accepted and `input_ready` is low in the sixth cycle. Exactly five results are produced, and the sixth pair never appears.
- **Extremes.**
  - A=−2^39, B=−2^31 → 2^70.
  - A=−2^39, B=2^31−1 → −2^39·(2^31−1).
  - A=0, B=−5 → 0.
- **Reset mid-operation.** Assert `reset` 10 cycles into BUSY with two more pairs queued → no pulse, `prod_data` = 0, and `input_ready` = 1 after release. A new pair (3, −7) then yields −21 with nominal latency.
